// File: rtl/bnn_pkg.sv
// Shared definitions for the binary conv front end: default geometry, FSM states
// and the bit-offset helper used to flatten a KxK window.
package bnn_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned K_DEF     = 5;
  localparam int unsigned MAX_W_DEF = 28;
  localparam int unsigned CW_DEF    = $clog2(MAX_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bit offset of window element (r,c); r=0 oldest row, c=0 leftmost column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k  = K_DEF,
                                          input int unsigned dw = DW_DEF);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/line_buf.sv
// Circular single-row delay: output is the pixel written exactly w enables ago.
module line_buf
  import bnn_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned MAX_W = MAX_W_DEF,
  parameter int unsigned CW    = $clog2(MAX_W + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] w,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [MAX_W];
  logic [CW-1:0] ptr;

  // Read-before-write at the same address gives a delay of w enables.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      ptr <= '0;
    else if (clr)   ptr <= '0;
    else if (en)    ptr <= (ptr == w - 1'b1) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/window_gen.sv
// Raster-stream to KxK sliding window generator with runtime image width,
// stall-tolerant input and per-window coordinates.
module window_gen
  import bnn_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned K     = K_DEF,
  parameter int unsigned MAX_W = MAX_W_DEF,
  parameter int unsigned CW    = $clog2(MAX_W + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CW-1:0]     img_w,
  input  logic              din_valid,
  input  logic [DW-1:0]     din,
  output logic [K*K*DW-1:0] win,
  output logic              win_valid,
  output logic [CW-1:0]     win_row,
  output logic [CW-1:0]     win_col,
  output logic              frame_done,
  output logic              busy,
  output logic              cfg_err
);

  state_t        state, state_n;
  logic [CW-1:0] w_q, ic, ir;
  logic          w_ok, start_ok, acc, last_px;

  logic [DW-1:0] win_q   [K][K];
  logic [DW-1:0] col_new [K];
  logic [DW-1:0] lb_in   [K-1];
  logic [DW-1:0] lb_out  [K-1];

  assign w_ok     = (img_w >= CW'(K)) && (img_w <= CW'(MAX_W));
  assign start_ok = (state == IDLE) && start && w_ok;
  assign acc      = (state == RUN) && din_valid;
  assign last_px  = (ir == w_q - 1'b1) && (ic == w_q - 1'b1);

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_in[i] = din;
    end else begin : g_tail
      assign lb_in[i] = lb_out[i-1];
    end
    line_buf #(.DW(DW), .MAX_W(MAX_W), .CW(CW)) u_lb (
      .clk  (clk),
      .rstn (rstn),
      .clr  (start_ok),
      .en   (acc),
      .w    (w_q),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  // Deepest line buffer holds the oldest row, so it feeds row 0.
  always_comb begin
    col_new[K-1] = din;
    for (int unsigned r = 0; r < K - 1; r++) col_new[r] = lb_out[K-2-r];
  end

  always_comb begin
    win = '0;
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        win[win_idx(r, c, K, DW) +: DW] = win_q[r][c];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = RUN;
      RUN:     if (acc && last_px) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      w_q        <= '0;
      ic         <= '0;
      ir         <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n == RUN);
      frame_done <= (state_n == DONE);
      cfg_err    <= (state == IDLE) && start && !w_ok;
      win_valid  <= acc && (ir >= CW'(K-1)) && (ic >= CW'(K-1));
      if (start_ok) begin
        w_q <= img_w;
        ic  <= '0;
        ir  <= '0;
      end else if (acc) begin
        win_row <= ir - CW'(K-1);
        win_col <= ic - CW'(K-1);
        if (ic == w_q - 1'b1) begin
          ic <= '0;
          ir <= ir + 1'b1;
        end else begin
          ic <= ic + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) win_q[r][c] <= '0;
    end else if (acc) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= col_new[r];
      end
    end
  end

endmodule
